// File: rtl/draw_pkg.sv
// Shared definitions for the rectangle draw arbiter: FSM encoding, display
// defaults, bus widths and the edge-clipping helper.
package draw_pkg;

  // Display defaults (portrait 240x320 panel).
  localparam int LCD_WIDTH_DEFAULT  = 240;
  localparam int LCD_HEIGHT_DEFAULT = 320;

  // Bus widths of one requester slice.
  localparam int COLOUR_W = 16;  // RGB565
  localparam int X_W      = 8;
  localparam int Y_W      = 9;
  localparam int W_W      = 8;
  localparam int H_W      = 9;

  // Width used for clipping arithmetic; wide enough that limit - origin
  // and the comparisons never wrap for any 8/9-bit origin.
  localparam int CLIP_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_BUSY   = 3'd3,
    ST_FINISH = 3'd4,
    ST_REJECT = 3'd5
  } state_t;

  // Length of a span that starts at origin, limited so it ends at the
  // display edge. Caller guarantees origin < limit.
  function automatic logic [CLIP_W-1:0] clip_len(
    input logic [CLIP_W-1:0] origin,
    input logic [CLIP_W-1:0] len,
    input logic [CLIP_W-1:0] limit
  );
    logic [CLIP_W-1:0] avail;
    avail = limit - origin;
    return (len < avail) ? len : avail;
  endfunction

endpackage

// File: rtl/draw_arbiter_rr.sv
// Round-robin winner selection: the requester after 'last' has highest
// priority, wrapping around. Purely combinational; the caller registers
// the result.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] winner
);

  // Walk from farthest to nearest candidate so the nearest asking one wins.
  always_comb begin
    winner = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NUM_REQ]) begin
        winner = '0;
        winner[(int'(last) + k) % NUM_REQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// Arbitrates rectangle-fill requests from several clients onto a single
// fill engine. The winner's rectangle is captured, validated and clipped to
// the display, then handed to the engine with a draw/ready handshake.
module draw_arbiter
  import draw_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int LCD_WIDTH  = LCD_WIDTH_DEFAULT,
  parameter int LCD_HEIGHT = LCD_HEIGHT_DEFAULT
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [X_W*NUM_REQ-1:0]      reqX,
  input  logic [Y_W*NUM_REQ-1:0]      reqY,
  input  logic [W_W*NUM_REQ-1:0]      reqW,
  input  logic [H_W*NUM_REQ-1:0]      reqH,
  input  logic [COLOUR_W*NUM_REQ-1:0] reqColour,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          done,
  output logic [NUM_REQ-1:0]          error,
  output logic                        draw,
  output logic [X_W-1:0]              drawX,
  output logic [Y_W-1:0]              drawY,
  output logic [W_W-1:0]              drawW,
  output logic [H_W-1:0]              drawH,
  output logic [COLOUR_W-1:0]         drawColour,
  input  logic                        drawReady
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [CLIP_W-1:0] W_LIM = CLIP_W'(LCD_WIDTH);
  localparam logic [CLIP_W-1:0] H_LIM = CLIP_W'(LCD_HEIGHT);
  localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NUM_REQ - 1);

  state_t state_q, state_d;

  // Per-requester views of the packed input buses.
  logic [X_W-1:0]      x_arr [NUM_REQ];
  logic [Y_W-1:0]      y_arr [NUM_REQ];
  logic [W_W-1:0]      w_arr [NUM_REQ];
  logic [H_W-1:0]      h_arr [NUM_REQ];
  logic [COLOUR_W-1:0] c_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign x_arr[gi] = reqX[gi*X_W +: X_W];
    assign y_arr[gi] = reqY[gi*Y_W +: Y_W];
    assign w_arr[gi] = reqW[gi*W_W +: W_W];
    assign h_arr[gi] = reqH[gi*H_W +: H_W];
    assign c_arr[gi] = reqColour[gi*COLOUR_W +: COLOUR_W];
  end

  // Round-robin pointer and current winner.
  logic [IDX_W-1:0]   last_q, last_d;
  logic [NUM_REQ-1:0] winner;
  logic [IDX_W-1:0]   grant_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req    (req),
    .last   (last_q),
    .winner (winner)
  );

  // Rectangle captured from the winner; isolated from later input changes.
  logic [X_W-1:0]      rx_q, rx_d;
  logic [Y_W-1:0]      ry_q, ry_d;
  logic [W_W-1:0]      rw_q, rw_d;
  logic [H_W-1:0]      rh_q, rh_d;
  logic [COLOUR_W-1:0] rc_q, rc_d;

  // Winner's rectangle, selected from the one-hot winner vector.
  logic [X_W-1:0]      sel_x;
  logic [Y_W-1:0]      sel_y;
  logic [W_W-1:0]      sel_w;
  logic [H_W-1:0]      sel_h;
  logic [COLOUR_W-1:0] sel_c;

  // Registered outputs.
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [NUM_REQ-1:0]  error_q, error_d;
  logic                draw_q, draw_d;
  logic [X_W-1:0]      dx_q, dx_d;
  logic [Y_W-1:0]      dy_q, dy_d;
  logic [W_W-1:0]      dw_q, dw_d;
  logic [H_W-1:0]      dh_q, dh_d;
  logic [COLOUR_W-1:0] dc_q, dc_d;

  // Validation of the captured rectangle.
  logic [CLIP_W-1:0] ext_x, ext_y;
  logic              reject;

  // Mux the winner's rectangle out of the per-requester arrays.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_w = '0;
    sel_h = '0;
    sel_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) begin
        sel_x = x_arr[i];
        sel_y = y_arr[i];
        sel_w = w_arr[i];
        sel_h = h_arr[i];
        sel_c = c_arr[i];
      end
    end
  end

  // Index of the requester currently being served, used to update last.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) grant_idx = IDX_W'(i);
    end
  end

  // Reject empty rectangles and those whose origin lies off-screen.
  always_comb begin
    ext_x  = CLIP_W'(rx_q);
    ext_y  = CLIP_W'(ry_q);
    reject = (rw_q == '0) || (rh_q == '0) || (ext_x >= W_LIM) || (ext_y >= H_LIM);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. ISSUE leaves only once the engine has seen draw high
  // and dropped ready, so a command is never lost.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (|req) state_d = ST_CHECK;
      ST_CHECK:  state_d = reject ? ST_REJECT : ST_ISSUE;
      ST_ISSUE:  if (draw_q && !drawReady) state_d = ST_BUSY;
      ST_BUSY:   if (drawReady) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      ST_REJECT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic: grant, pulses, draw strobe and clipped rectangle.
  always_comb begin
    grant_d = grant_q;
    done_d  = '0;
    error_d = '0;
    draw_d  = 1'b0;
    dx_d    = dx_q;
    dy_d    = dy_q;
    dw_d    = dw_q;
    dh_d    = dh_q;
    dc_d    = dc_q;
    unique case (state_q)
      ST_IDLE: grant_d = winner;
      ST_CHECK: begin
        if (reject) begin
          error_d = grant_q;
        end else begin
          dx_d = rx_q;
          dy_d = ry_q;
          dw_d = W_W'(clip_len(ext_x, CLIP_W'(rw_q), W_LIM));
          dh_d = H_W'(clip_len(ext_y, CLIP_W'(rh_q), H_LIM));
          dc_d = rc_q;
        end
      end
      // draw rises on the second ISSUE cycle and falls on the way out.
      ST_ISSUE: draw_d = (state_d == ST_ISSUE);
      ST_BUSY:  if (state_d == ST_FINISH) done_d = grant_q;
      ST_FINISH, ST_REJECT: grant_d = '0;
      default:  grant_d = '0;
    endcase
  end

  // Capture the winner's rectangle and advance the round-robin pointer.
  always_comb begin
    rx_d   = rx_q;
    ry_d   = ry_q;
    rw_d   = rw_q;
    rh_d   = rh_q;
    rc_d   = rc_q;
    last_d = last_q;
    if (state_q == ST_IDLE && (|req)) begin
      rx_d = sel_x;
      ry_d = sel_y;
      rw_d = sel_w;
      rh_d = sel_h;
      rc_d = sel_c;
    end
    if (state_q == ST_FINISH || state_q == ST_REJECT) begin
      last_d = grant_idx;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_q  <= LAST_RST;
      rx_q    <= '0;
      ry_q    <= '0;
      rw_q    <= '0;
      rh_q    <= '0;
      rc_q    <= '0;
      grant_q <= '0;
      done_q  <= '0;
      error_q <= '0;
      draw_q  <= 1'b0;
      dx_q    <= '0;
      dy_q    <= '0;
      dw_q    <= '0;
      dh_q    <= '0;
      dc_q    <= '0;
    end else begin
      last_q  <= last_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      rw_q    <= rw_d;
      rh_q    <= rh_d;
      rc_q    <= rc_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      error_q <= error_d;
      draw_q  <= draw_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      dw_q    <= dw_d;
      dh_q    <= dh_d;
      dc_q    <= dc_d;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign error      = error_q;
  assign draw       = draw_q;
  assign drawX      = dx_q;
  assign drawY      = dy_q;
  assign drawW      = dw_q;
  assign drawH      = dh_q;
  assign drawColour = dc_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// Bench for draw_arbiter: directed scenarios followed by randomized
// services, checked against a transaction-level model of arbitration,
// rejection and clipping, with a simple fill-engine model on drawReady.
`timescale 1ns/1ps
module tb_draw_arbiter;

  localparam int N  = 3;
  localparam int LW = 240;
  localparam int LH = 320;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req   = '0;
  logic [8*N-1:0] reqX  = '0;
  logic [9*N-1:0] reqY  = '0;
  logic [8*N-1:0] reqW  = '0;
  logic [9*N-1:0] reqH  = '0;
  logic [16*N-1:0] reqColour = '0;
  logic [N-1:0]   grant, done, error;
  logic           draw;
  logic [7:0]     drawX;
  logic [8:0]     drawY;
  logic [7:0]     drawW;
  logic [8:0]     drawH;
  logic [15:0]    drawColour;
  logic           drawReady = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  // Fill-engine model state and the arbitration model's round-robin pointer.
  int eng_busy = 4;
  int eng_cnt  = 0;
  int model_last = N - 1;

  // Rectangle table per requester.
  int tx [N];
  int ty [N];
  int tw [N];
  int th [N];
  int tc [N];

  draw_arbiter #(
    .NUM_REQ    (N),
    .LCD_WIDTH  (LW),
    .LCD_HEIGHT (LH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .reqX       (reqX),
    .reqY       (reqY),
    .reqW       (reqW),
    .reqH       (reqH),
    .reqColour  (reqColour),
    .grant      (grant),
    .done       (done),
    .error      (error),
    .draw       (draw),
    .drawX      (drawX),
    .drawY      (drawY),
    .drawW      (drawW),
    .drawH      (drawH),
    .drawColour (drawColour),
    .drawReady  (drawReady)
  );

  always #5 clock = ~clock;

  // Engine: accepts a draw while idle, then stays busy for eng_busy cycles.
  always @(posedge clock) begin
    if (reset) begin
      drawReady <= 1'b1;
      eng_cnt   <= 0;
    end else if (eng_cnt > 0) begin
      eng_cnt   <= eng_cnt - 1;
      drawReady <= (eng_cnt == 1);
    end else if (drawReady && draw) begin
      drawReady <= 1'b0;
      eng_cnt   <= eng_busy;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Invariants that hold on every cycle outside reset.
  always @(negedge clock) begin
    if (!reset) begin
      check("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
      check("draw_without_grant", 32'(draw && (grant == '0)), 32'd0);
    end
  end

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic drive_rects();
    for (int i = 0; i < N; i++) begin
      reqX[i*8 +: 8]       = 8'(tx[i]);
      reqY[i*9 +: 9]       = 9'(ty[i]);
      reqW[i*8 +: 8]       = 8'(tw[i]);
      reqH[i*9 +: 9]       = 9'(th[i]);
      reqColour[i*16 +: 16] = 16'(tc[i]);
    end
  endtask

  task automatic set_rect(input int i, input int x, input int y, input int w, input int h, input int c);
    tx[i] = x; ty[i] = y; tw[i] = w; th[i] = h; tc[i] = c;
    drive_rects();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    check("rst.grant", 32'(grant), 0);
    check("rst.done", 32'(done), 0);
    check("rst.error", 32'(error), 0);
    check("rst.draw", 32'(draw), 0);
    check("rst.rect", {drawX, drawY, drawW, drawH}, 0);
    check("rst.colour", 32'(drawColour), 0);
    @(negedge clock);
    reset = 1'b0;
    model_last = N - 1;
  endtask

  // One complete service, called at a negedge while the DUT is idle and req
  // is already applied. Optionally changes the winner's inputs and drops its
  // request while the engine is busy.
  task automatic service(input string tag, input bit mutate);
    int win, waited, draw_cyc;
    bit rej, saw_draw, mutated, finished;
    int ex, ey, ew, eh, ec;
    logic [N-1:0] onehot;
    win = rr_pick(req, model_last);
    if (win < 0) return;
    rej = (tw[win] == 0) || (th[win] == 0) || (tx[win] >= LW) || (ty[win] >= LH);
    ex = tx[win];
    ey = ty[win];
    ec = tc[win];
    ew = (tw[win] < LW - tx[win]) ? tw[win] : LW - tx[win];
    eh = (th[win] < LH - ty[win]) ? th[win] : LH - ty[win];
    onehot = '0;
    onehot[win] = 1'b1;

    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (grant == '0 && waited < 20);
    check({tag, ".grant_latency"}, 32'(waited), 32'd1);
    check({tag, ".grant"}, 32'(grant), 32'(onehot));

    saw_draw = 0; mutated = 0; finished = 0; draw_cyc = -1;
    for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
      @(negedge clock);
      if (done != '0 || error != '0) begin
        finished = 1;
        check({tag, ".done"}, 32'(done), rej ? 32'd0 : 32'(onehot));
        check({tag, ".error"}, 32'(error), rej ? 32'(onehot) : 32'd0);
        check({tag, ".grant_held"}, 32'(grant), 32'(onehot));
        check({tag, ".draw_seen"}, 32'(saw_draw), 32'(!rej));
        if (!rej) begin
          check({tag, ".draw_latency"}, 32'(draw_cyc), 32'd2);
          check({tag, ".drawX"}, 32'(drawX), 32'(ex));
          check({tag, ".drawY"}, 32'(drawY), 32'(ey));
          check({tag, ".drawW"}, 32'(drawW), 32'(ew));
          check({tag, ".drawH"}, 32'(drawH), 32'(eh));
          check({tag, ".colour"}, 32'(drawColour), 32'(ec));
        end
      end else if (draw) begin
        if (!saw_draw) draw_cyc = cyc;
        saw_draw = 1;
      end else if (saw_draw && mutate && !mutated) begin
        mutated = 1;
        req[win] = 1'b0;
        set_rect(win, int'($urandom_range(0, 255)), int'($urandom_range(0, 511)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 511)),
                 int'($urandom_range(0, 65535)));
      end
    end
    check({tag, ".completed"}, 32'(finished), 32'd1);
    if (finished) begin
      @(negedge clock);
      check({tag, ".pulse_end"}, 32'({done, error}), 32'd0);
      check({tag, ".grant_release"}, 32'(grant), 32'd0);
    end
    model_last = win;
    $display("service %s: requester %0d %s", tag, win, rej ? "rejected" : "drawn");
  endtask

  initial begin
    int waited;
    bit saw, in_busy;
    for (int i = 0; i < N; i++) set_rect(i, 0, 0, 1, 1, 0);
    do_reset();

    // Scenario 1: single requester, long engine busy period.
    eng_busy = 30;
    set_rect(0, 10, 20, 5, 4, 16'hF800);
    req = 3'b001;
    service("s1", 0);
    req = '0;

    // Scenario 2: all requesting continuously, fresh pointer.
    do_reset();
    eng_busy = 2;
    set_rect(0, 1, 2, 3, 4, 16'h1111);
    set_rect(1, 100, 200, 50, 60, 16'h2222);
    set_rect(2, 239, 319, 1, 1, 16'h3333);
    req = 3'b111;
    service("s2a", 0);
    service("s2b", 0);
    service("s2c", 0);
    service("s2d", 0);

    // Scenario 3: rectangle overhanging the bottom-right corner.
    req = 3'b001;
    set_rect(0, 230, 310, 20, 20, 16'h001F);
    service("s3", 0);

    // Scenario 4: two rejected rectangles, then a valid one.
    do_reset();
    set_rect(0, 240, 0, 5, 5, 16'hAAAA);
    set_rect(1, 0, 0, 0, 5, 16'hBBBB);
    set_rect(2, 100, 100, 10, 10, 16'hFFFF);
    req = 3'b111;
    service("s4a", 0);
    service("s4b", 0);
    service("s4c", 0);

    // Scenario 5: reset while the engine is busy.
    eng_busy = 10;
    set_rect(0, 5, 5, 5, 5, 16'h0F0F);
    req = 3'b001;
    saw = 0; in_busy = 0; waited = 0;
    while (!in_busy && waited < 60) begin
      @(negedge clock);
      waited++;
      if (draw) saw = 1;
      else if (saw) in_busy = 1;
    end
    check("s5.reached_busy", 32'(in_busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("s5.grant", 32'(grant), 0);
    check("s5.pulses", 32'({done, error}), 0);
    check("s5.draw", 32'(draw), 0);
    check("s5.rect", {drawX, drawY, drawW, drawH}, 0);
    check("s5.colour", 32'(drawColour), 0);
    reset = 1'b0;
    model_last = N - 1;
    set_rect(1, 20, 30, 40, 50, 16'h7E0);
    set_rect(2, 60, 70, 8, 9, 16'h1234);
    req = 3'b110;
    service("s5", 0);

    // Scenario 6: inputs change and request drops while the engine is busy.
    eng_busy = 6;
    set_rect(1, 50, 60, 30, 40, 16'h07E0);
    req = 3'b010;
    service("s6", 1);

    // Randomized services.
    for (int t = 0; t < 30; t++) begin
      eng_busy = int'($urandom_range(1, 8));
      for (int i = 0; i < N; i++) begin
        tx[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(225, 255)) : int'($urandom_range(0, 255));
        ty[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(300, 330)) : int'($urandom_range(0, 511));
        tw[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
        th[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 511));
        tc[i] = int'($urandom_range(0, 65535));
      end
      drive_rects();
      req = N'($urandom_range(1, (1 << N) - 1));
      service($sformatf("rnd%0d", t), bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
